// File: rtl/mem_bus_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_bus_ctrl_if
//   Groups the CPU request/response handshake and the mem address/strobe
//   outputs of mem_bus_ctrl. The bidirectional mem_data bus is kept out of
//   the interface. It is a plain inout on the controller, so that tristate
//   resolution stays on an ordinary net.
//
//   req_valid/req_ready/req_wr/req_addr/req_wdata : CPU -> controller request
//   resp_valid/resp_rdata                         : controller -> CPU response
//   mem_addr/mem_rd/mem_wr                        : controller -> mem strobes
//
//   modport master : requester view (CPU side, drives the request)
//   modport slave  : controller view (serves the request, drives mem)
// ----------------------------------------------------------------------------
interface mem_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_rd, mem_wr
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// ----------------------------------------------------------------------------
// mem_bus_ctrl
//   Bus master placed directly upstream of the mem block. It accepts one
//   load/store at a time over a valid/ready handshake. It holds mem_addr and
//   the rd/wr strobe for WAIT_CYCLES+1 cycles, then issues a one-cycle
//   resp_valid. Loads capture mem_data into resp_rdata. Stores add a single
//   turnaround cycle, so that a mem read never directly follows a cycle in
//   which the controller drove the bus.
//
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : mem_bus_ctrl_if.slave (request, response, mem addr/strobes)
//   mem_data   : shared data bus, driven only while mem_wr=1, else high-Z
// ----------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1    // legal range 0..15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_bus_ctrl_if.slave         bus,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // NOTE: every variable gets a default at the top of always_comb. Without
  // one, any branch that skips an assignment infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        // ready_q is low for the first cycle after reset. A request there is
        // not a handshake, even though the state is already IDLE.
        if (bus.req_valid && ready_q) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rd_d    = ~bus.req_wr;
          wr_d    = bus.req_wr;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          if (rd_q) rdata_d = mem_data;
          // A load frees the controller at once, so the CPU can issue
          // back-to-back loads. A store first lets the bus turn around.
          state_d = wr_q ? TURN : IDLE;
          ready_d = ~wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      TURN: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from the values of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  // The enable is the registered write strobe itself. The bus is therefore
  // released in the same cycle that mem_wr drops, including on async reset.
  assign mem_data = wr_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd     = rd_q;
  assign bus.mem_wr     = wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_ctrl
//   Main instance uses WAIT_CYCLES=1, with a word-array mem model and a
//   scoreboard queue. The queue is pushed at each handshake and popped on
//   resp_valid. Two more instances (WAIT_CYCLES=0 and 3) run a store/load
//   at 0xFFFF and measure strobe width. Whenever no side should drive
//   mem_data, the bench drives a known pattern onto it. Any stray drive by
//   the controller therefore shows up as a corrupted bus value.
// ----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  localparam logic [31:0] SENT = 32'h5A5A_C3C3;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_resp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main instance, WAIT_CYCLES = 1 ----------------
  mem_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) b1();
  wire [31:0] mem_data1;

  mem_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b1.slave),
    .mem_data (mem_data1)
  );

  logic [31:0] mem1 [0:65535];
  logic        pend_v;
  logic [15:0] pend_a;
  logic [31:0] pend_d;

  assign mem_data1 = b1.mem_rd ? mem1[b1.mem_addr] :
                     (!b1.mem_wr ? SENT : 32'bz);

  // Store data takes effect when the controller reports completion. A store
  // aborted by reset never reaches the array.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_v <= 1'b0;
    end else begin
      if (b1.mem_wr) begin
        pend_v <= 1'b1;
        pend_a <= b1.mem_addr;
        pend_d <= mem_data1;
      end
      if (b1.resp_valid && pend_v) begin
        mem1[pend_a] <= pend_d;
        pend_v       <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard and bus monitor ----------------
  txn_t sb[$];
  txn_t mon_e;
  int   strobe_cnt = 0;
  bit   turn_chk   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_cnt <= 0;
      turn_chk   <= 1'b0;
    end else begin
      check("rd_wr_exclusive", 32'(b1.mem_rd & b1.mem_wr), 0);
      if (!b1.mem_rd && !b1.mem_wr) check("bus_z_when_idle", mem_data1, SENT);
      if (turn_chk) begin
        check("ready_after_turn", 32'(b1.req_ready), 1);
        turn_chk <= 1'b0;
      end
      if (b1.mem_rd || b1.mem_wr) begin
        strobe_cnt <= strobe_cnt + 1;
        if (sb.size() == 0) begin
          check("strobe_without_req", sb.size(), 1);
        end else begin
          check("mem_addr", 32'(b1.mem_addr), 32'(sb[0].addr));
          check("mem_wr_dir", 32'(b1.mem_wr), 32'(sb[0].wr));
          if (b1.mem_wr) check("mem_data_drive", mem_data1, sb[0].wdata);
        end
      end else if (strobe_cnt != 0) begin
        check("strobe_width", strobe_cnt, 2);
        check("resp_after_strobe", 32'(b1.resp_valid), 1);
        strobe_cnt <= 0;
      end
      if (b1.resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check(mon_e.wr ? "resp_rdata_store" : "resp_rdata_load", b1.resp_rdata, mon_e.rdata);
          check("ready_with_resp", 32'(b1.req_ready), 32'(!mon_e.wr));
          if (mon_e.wr) turn_chk <= 1'b1;
          n_resp <= n_resp + 1;
        end
      end
    end
  end

  // ---------------- request driver ----------------
  logic [31:0] model_rdata = '0;

  task automatic push_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp);
    txn_t e;
    if (!wr) model_rdata = exp;
    e = '{wr, addr, wdata, model_rdata};
    sb.push_back(e);
    n_acc++;
  endtask

  // Called at a falling edge. Holds the request until accepted, then drops it.
  task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp);
    bit acc = 1'b0;
    b1.req_valid = 1'b1;
    b1.req_wr    = wr;
    b1.req_addr  = addr;
    b1.req_wdata = wdata;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (b1.req_ready) acc = 1'b1;
      else @(negedge clk);
    end
    check("accept_timeout", 32'(acc), 1);
    if (acc) begin
      push_txn(wr, addr, wdata, exp);
      @(posedge clk);
      @(negedge clk);
    end
    b1.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- WAIT_CYCLES = 0 and 3 instances ----------------
  for (genvar g = 0; g < 2; g++) begin : gen_w
    localparam int W = (g == 0) ? 0 : 3;
    mem_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bx();
    wire  [31:0] md;
    logic [31:0] word;
    logic        done;

    mem_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut_w (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bx.slave),
      .mem_data (md)
    );

    assign md = bx.mem_rd ? word : 32'bz;
    always @(posedge clk) if (bx.mem_wr) word <= md;

    initial begin
      done         = 1'b0;
      word         = '0;
      bx.req_valid = 1'b0;
      bx.req_wr    = 1'b0;
      bx.req_addr  = '0;
      bx.req_wdata = '0;
      wait (rst_n === 1'b1);
      repeat (2) @(negedge clk);
      for (int op = 0; op < 2; op++) begin
        int width;
        bit seen;
        bit acc;
        bx.req_valid = 1'b1;
        bx.req_wr    = (op == 0);
        bx.req_addr  = 16'hFFFF;
        bx.req_wdata = 32'hDEAD_BEEF;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
          if (bx.req_ready) acc = 1'b1;
          else @(negedge clk);
        end
        check($sformatf("w%0d_accept", W), 32'(acc), 1);
        @(posedge clk);
        @(negedge clk);
        bx.req_valid = 1'b0;
        width = 0;
        seen  = 1'b0;
        for (int c = 0; c < 25 && !seen; c++) begin
          if (bx.mem_rd || bx.mem_wr) begin
            width++;
            check($sformatf("w%0d_mem_addr", W), 32'(bx.mem_addr), 32'hFFFF);
          end
          if (bx.resp_valid) begin
            seen = 1'b1;
            if (op == 1) check($sformatf("w%0d_rdata", W), bx.resp_rdata, 32'hDEAD_BEEF);
          end else begin
            @(negedge clk);
          end
        end
        check($sformatf("w%0d_strobe_width_%s", W, op == 0 ? "st" : "ld"), width, W + 1);
        check($sformatf("w%0d_resp_seen", W), 32'(seen), 1);
        repeat (2) @(negedge clk);
      end
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  txn_t vecs [11];
  logic [15:0] last_a;
  logic [31:0] last_d;

  initial begin
    // {wr, addr, wdata, expected rdata for loads}
    vecs[0]  = '{1'b1, 16'd14,    32'd321,        32'd0};
    vecs[1]  = '{1'b1, 16'd15,    32'd213,        32'd0};
    vecs[2]  = '{1'b0, 16'd14,    32'd0,          32'd321};
    vecs[3]  = '{1'b0, 16'd15,    32'd0,          32'd213};
    vecs[4]  = '{1'b1, 16'hFFFF,  32'hDEAD_BEEF,  32'd0};
    vecs[5]  = '{1'b0, 16'hFFFF,  32'd0,          32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 16'd0,     32'h0000_0001,  32'd0};
    vecs[7]  = '{1'b0, 16'd0,     32'd0,          32'h0000_0001};
    vecs[8]  = '{1'b1, 16'd14,    32'h0000_0000,  32'd0};
    vecs[9]  = '{1'b0, 16'd14,    32'd0,          32'h0000_0000};
    vecs[10] = '{1'b0, 16'd15,    32'd0,          32'd213};

    rst_n        = 1'b0;
    b1.req_valid = 1'b0;
    b1.req_wr    = 1'b0;
    b1.req_addr  = '0;
    b1.req_wdata = '0;
    mem1[20]     = 32'h0BAD_F00D;

    #3;
    check("rst_req_ready",  32'(b1.req_ready), 0);
    check("rst_resp_valid", 32'(b1.resp_valid), 0);
    check("rst_resp_rdata", b1.resp_rdata, 0);
    check("rst_mem_rd",     32'(b1.mem_rd), 0);
    check("rst_mem_wr",     32'(b1.mem_wr), 0);
    check("rst_mem_addr",   32'(b1.mem_addr), 0);
    check("rst_mem_data_z", mem_data1, SENT);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 32'(b1.req_ready), 1);

    // Table: consecutive sends are issued without idle gaps, so loads 2->3
    // exercise the no-bubble back-to-back path.
    foreach (vecs[i]) send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
    drain();

    // req_valid held high while the address keeps changing. Only fields
    // present at a handshake may appear on the bus.
    b1.req_valid = 1'b1;
    b1.req_wr    = 1'b1;
    for (int c = 0; c < 14; c++) begin
      b1.req_addr  = 16'(300 + c);
      b1.req_wdata = 32'h1000_0000 + 32'(c);
      if (b1.req_ready) begin
        push_txn(1'b1, b1.req_addr, b1.req_wdata, 32'd0);
        last_a = b1.req_addr;
        last_d = b1.req_wdata;
      end
      @(negedge clk);
    end
    b1.req_valid = 1'b0;
    drain();
    check("resp_per_handshake", n_resp, n_acc);
    send(1'b0, last_a, 32'd0, last_d);
    drain();

    for (int i = 0; i < 300 && !(gen_w[0].done && gen_w[1].done); i++) @(negedge clk);
    check("wide_builds_done", 32'(gen_w[0].done && gen_w[1].done), 1);

    // Reset in the middle of a store to addr 20. The store must vanish.
    b1.req_valid = 1'b1;
    b1.req_wr    = 1'b1;
    b1.req_addr  = 16'd20;
    b1.req_wdata = 32'h1234_5678;
    check("rst_pre_ready", 32'(b1.req_ready), 1);
    push_txn(1'b1, 16'd20, 32'h1234_5678, 32'd0);
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0;
    check("rst_pre_mem_wr", 32'(b1.mem_wr), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_mem_wr",     32'(b1.mem_wr), 0);
    check("rst_async_mem_data_z", mem_data1, SENT);
    check("rst_async_resp_valid", 32'(b1.resp_valid), 0);
    check("rst_async_req_ready",  32'(b1.req_ready), 0);
    sb.delete();
    model_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(1'b0, 16'd20, 32'd0, 32'h0BAD_F00D);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Bus master sitting directly upstream of the mem block. It accepts single load/store requests from the CPU over a valid/ready handshake. It drives mem's addr, rd and wr strobes and the bidirectional 32-bit data bus for a programmable number of cycles. It then returns a one-cycle response carrying read data.

Parameters:
ADDR_WIDTH, 16, width of req_addr and mem_addr
DATA_WIDTH, 32, width of the data paths and the mem_data bus
WAIT_CYCLES, 1, extra cycles the strobe is held beyond the first; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  controller can accept a request this cycle
req_wr  input  1  1 = store, 0 = load
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  store data
resp_valid  output  1  one-cycle pulse: transaction complete
resp_rdata  output  DATA_WIDTH  load data; holds last value until next load completes
mem_addr  output  ADDR_WIDTH  address to mem
mem_rd  output  1  read strobe to mem
mem_wr  output  1  write strobe to mem
mem_data  inout  DATA_WIDTH  shared data bus; driven only while mem_wr=1, else high-Z

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_rd=0, mem_wr=0, mem_addr=0, mem_data=Z.
  - resp_valid=0, resp_rdata=0, req_ready=0 while rst_n=0.
  - Any transaction in flight is dropped; no response is ever issued for it.
- States: IDLE, ACCESS, TURN.
- All outputs except the mem_data tristate enable are registered.
- IDLE:
  - req_ready=1.
  - On rising edge with req_valid&req_ready: latch addr, wdata and wr; load wait counter with WAIT_CYCLES; go to ACCESS.
  - mem_addr is updated at the same edge.
  - mem_rd=~req_wr and mem_wr=req_wr are asserted at the same edge.
- ACCESS:
  - req_ready=0.
  - Strobe and address held stable for WAIT_CYCLES+1 cycles; counter decrements each cycle.
  - Last cycle is counter==0.
  - Load: at the edge ending the last cycle, capture mem_data into resp_rdata; drop mem_rd; go to IDLE; pulse resp_valid.
  - Store: at the edge ending the last cycle, drop mem_wr (mem_data goes Z in the same cycle); go to TURN; pulse resp_valid.
- TURN:
  - One bus-turnaround cycle with req_ready=0.
  - Then go to IDLE.
  - Guarantees no cycle in which the controller drives mem_data immediately before a mem read.
- Invariants:
  - mem_rd and mem_wr are never 1 together.
  - mem_data is Z whenever mem_wr=0.
  - resp_valid is high for exactly one cycle per accepted request.
- Latency (WAIT_CYCLES=W), handshake at edge T:
  - Strobe high for cycles T..T+W.
  - resp_valid high in cycle T+W+1.
  - Load: req_ready is high again in cycle T+W+1, so back-to-back loads issue every W+2 cycles.
  - Store: req_ready returns in cycle T+W+2.
- req_valid while req_ready=0 is ignored; the CPU must hold the request until accepted.
- Request fields are sampled only at acceptance; later changes have no effect.
- Address wrap: mem_addr is taken verbatim from req_addr; no increment.
- resp_rdata is unchanged by stores.

Test Plan:
- W=1: store addr=14 data=321, then store addr=15 data=213, then load addr=14 -> resp_rdata=321 on resp_valid; mem_wr high exactly 2 cycles per store; mem_data=Z outside the mem_wr window.
- Load addr=15 issued in the same cycle as the resp_valid of the previous load -> accepted with no bubble; resp_rdata=213.
- W=0 and W=3 builds: store/load at addr=0xFFFF with data=0xDEADBEEF -> strobe width 1 and 4 cycles respectively; data read back 0xDEADBEEF.
- Hold req_valid=1 continuously with changing req_addr during ACCESS -> only the accepted address appears on mem_addr; exactly one resp_valid per handshake.
- Assert rst_n=0 mid-ACCESS of a store to addr=20 -> mem_wr=0 and mem_data=Z immediately (asynchronously), no resp_valid; after release, a load of addr=20 returns the pre-store value.
- Every cycle, checker asserts !(mem_rd&mem_wr), and that mem_data==Z whenever mem_wr=0 from the controller side.
